// File: rtl/chess_turn_controller.sv
// Two-player chess clock: button edge detection, turn FSM, per-player
// countdown timers with increment on turn end and flag-fall detection.
module chess_turn_controller #(
    parameter int unsigned TIME_W    = 3,
    parameter int unsigned INIT_TIME = 7,
    parameter int unsigned INC       = 0
) (
    input  logic              clk_four,
    input  logic              reset,
    input  logic              start_button,
    input  logic              button1,
    input  logic              button2,
    input  logic              tick,
    output logic              player,
    output logic              running,
    output logic [TIME_W-1:0] timer1,
    output logic [TIME_W-1:0] timer2,
    output logic              zero1,
    output logic              zero2,
    output logic [2:0]        state
);

    localparam int unsigned SUM_W = TIME_W + 32;
    localparam logic [TIME_W-1:0] INIT_VAL = TIME_W'(INIT_TIME);
    localparam logic [SUM_W-1:0]  MAX_SUM  = SUM_W'({TIME_W{1'b1}});
    localparam logic [SUM_W-1:0]  INC_SUM  = SUM_W'(INC);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN1  = 3'd1,
        RUN2  = 3'd2,
        PAUSE = 3'd3,
        FLAG  = 3'd4
    } state_t;

    state_t fsm;
    logic   paused_player;

    // Input registers: {start, button2, button1}
    logic [2:0] btn_cur;
    logic [2:0] btn_prev;
    logic [2:0] btn_armed;
    logic       tick_q;
    logic [2:0] press;
    logic       start_p;
    logic       b1_p;
    logic       b2_p;

    // A button only arms once it has been seen low, so a level held
    // through reset cannot masquerade as a fresh press.
    always_ff @(posedge clk_four or posedge reset) begin
        if (reset) begin
            btn_cur   <= 3'b000;
            btn_prev  <= 3'b000;
            btn_armed <= 3'b000;
            tick_q    <= 1'b0;
        end else begin
            btn_cur   <= {start_button, button2, button1};
            btn_prev  <= btn_cur;
            btn_armed <= btn_armed | ~{start_button, button2, button1};
            tick_q    <= tick;
        end
    end

    assign press   = btn_cur & ~btn_prev & btn_armed;
    assign start_p = press[2];
    assign b2_p    = press[1];
    assign b1_p    = press[0];

    // Next value of the active player's timer: decrement, then flag or increment
    logic [TIME_W-1:0] act_time;
    logic [TIME_W-1:0] act_dec;
    logic [TIME_W-1:0] act_inc;
    logic [TIME_W-1:0] act_next;
    logic [SUM_W-1:0]  act_sum;
    logic              act_press;
    logic              act_flag;

    always_comb begin
        act_time  = (fsm == RUN2) ? timer2 : timer1;
        act_press = (fsm == RUN2) ? b2_p : b1_p;
        act_flag  = tick_q && (act_time == TIME_W'(1));
        act_dec   = (tick_q && (act_time != '0)) ? act_time - TIME_W'(1) : act_time;
        act_sum   = SUM_W'(act_dec) + INC_SUM;
        act_inc   = (act_sum > MAX_SUM) ? {TIME_W{1'b1}} : act_sum[TIME_W-1:0];
        if (act_flag) begin
            act_next = '0;
        end else if (act_press) begin
            act_next = act_inc;
        end else begin
            act_next = act_dec;
        end
    end

    always_ff @(posedge clk_four or posedge reset) begin
        if (reset) begin
            fsm           <= IDLE;
            player        <= 1'b0;
            running       <= 1'b0;
            timer1        <= INIT_VAL;
            timer2        <= INIT_VAL;
            zero1         <= 1'b0;
            zero2         <= 1'b0;
            paused_player <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    timer1 <= INIT_VAL;
                    timer2 <= INIT_VAL;
                    if (start_p) begin
                        fsm     <= RUN1;
                        player  <= 1'b0;
                        running <= 1'b1;
                    end
                end
                RUN1, RUN2: begin
                    if (start_p) begin
                        fsm           <= PAUSE;
                        running       <= 1'b0;
                        paused_player <= (fsm == RUN2);
                    end else begin
                        if (fsm == RUN1) begin
                            timer1 <= act_next;
                        end else begin
                            timer2 <= act_next;
                        end
                        if (act_flag) begin
                            fsm     <= FLAG;
                            running <= 1'b0;
                            if (fsm == RUN1) begin
                                zero1 <= 1'b1;
                            end else begin
                                zero2 <= 1'b1;
                            end
                        end else if (act_press) begin
                            fsm    <= (fsm == RUN1) ? RUN2 : RUN1;
                            player <= (fsm == RUN1);
                        end
                    end
                end
                PAUSE: begin
                    if (start_p) begin
                        fsm     <= paused_player ? RUN2 : RUN1;
                        player  <= paused_player;
                        running <= 1'b1;
                    end
                end
                FLAG: begin
                    if (start_p) begin
                        fsm    <= IDLE;
                        player <= 1'b0;
                        timer1 <= INIT_VAL;
                        timer2 <= INIT_VAL;
                        zero1  <= 1'b0;
                        zero2  <= 1'b0;
                    end
                end
                default: begin
                    fsm     <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign state = fsm;

endmodule

// File: tb/tb_chess_turn_controller.sv
// Directed bench for chess_turn_controller with INC=1 (TIME_W=3, INIT_TIME=7).
module tb_chess_turn_controller;

    logic       clk_four;
    logic       reset;
    logic       start_button;
    logic       button1;
    logic       button2;
    logic       tick;
    logic       player;
    logic       running;
    logic [2:0] timer1;
    logic [2:0] timer2;
    logic       zero1;
    logic       zero2;
    logic [2:0] state;

    int total;
    int bad;

    chess_turn_controller #(
        .TIME_W   (3),
        .INIT_TIME(7),
        .INC      (1)
    ) dut (
        .clk_four    (clk_four),
        .reset       (reset),
        .start_button(start_button),
        .button1     (button1),
        .button2     (button2),
        .tick        (tick),
        .player      (player),
        .running     (running),
        .timer1      (timer1),
        .timer2      (timer2),
        .zero1       (zero1),
        .zero2       (zero2),
        .state       (state)
    );

    initial clk_four = 1'b0;
    always #5 clk_four = ~clk_four;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic expect_all(input string tag, input int st, input int pl, input int rn,
                              input int t1, input int t2, input int z1, input int z2);
        check_eq({tag, ".state"},   32'(state),   32'(st));
        check_eq({tag, ".player"},  32'(player),  32'(pl));
        check_eq({tag, ".running"}, 32'(running), 32'(rn));
        check_eq({tag, ".timer1"},  32'(timer1),  32'(t1));
        check_eq({tag, ".timer2"},  32'(timer2),  32'(t2));
        check_eq({tag, ".zero1"},   32'(zero1),   32'(z1));
        check_eq({tag, ".zero2"},   32'(zero2),   32'(z2));
    endtask

    task automatic cyc();
        @(posedge clk_four);
        #1;
    endtask

    // One-cycle input pulse; its effect is visible after the second edge
    task automatic pulse(input logic s, input logic b1, input logic b2, input logic t);
        start_button = s;
        button1      = b1;
        button2      = b2;
        tick         = t;
        cyc();
        start_button = 1'b0;
        button1      = 1'b0;
        button2      = 1'b0;
        tick         = 1'b0;
        cyc();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) pulse(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        start_button = 1'b0;
        button1      = 1'b0;
        button2      = 1'b0;
        tick         = 1'b0;
        reset        = 1'b1;
        #1;
        expect_all("rst", 0, 0, 0, 7, 7, 0, 0);
        cyc();
        reset = 1'b0;
        cyc();

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("start", 1, 0, 1, 7, 7, 0, 0);
        ticks(3);
        expect_all("run1_3t", 1, 0, 1, 4, 7, 0, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("b2_ign", 1, 0, 1, 4, 7, 0, 0);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        expect_all("both_b", 2, 1, 1, 5, 7, 0, 0);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("pause2", 3, 1, 0, 5, 7, 0, 0);
        ticks(5);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        expect_all("pause_hold", 3, 1, 0, 5, 7, 0, 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("resume2", 2, 1, 1, 5, 7, 0, 0);

        ticks(1);
        expect_all("run2_t", 2, 1, 1, 5, 6, 0, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("b2_inc", 1, 0, 1, 5, 7, 0, 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        expect_all("b1_inc", 2, 1, 1, 6, 7, 0, 0);
        pulse(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("sat2", 1, 0, 1, 6, 7, 0, 0);

        pulse(1'b1, 1'b1, 1'b0, 1'b0);
        expect_all("start_prio", 3, 0, 0, 6, 7, 0, 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("resume1", 1, 0, 1, 6, 7, 0, 0);

        ticks(5);
        expect_all("t1_one", 1, 0, 1, 1, 7, 0, 0);
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        expect_all("flag1", 4, 0, 0, 0, 7, 1, 0);
        ticks(2);
        pulse(1'b0, 1'b1, 1'b1, 1'b0);
        expect_all("flag_hold", 4, 0, 0, 0, 7, 1, 0);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("rearm", 0, 0, 0, 7, 7, 0, 0);
        ticks(1);
        expect_all("idle_hold", 0, 0, 0, 7, 7, 0, 0);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        ticks(2);
        pulse(1'b0, 1'b1, 1'b0, 1'b1);
        expect_all("tick_sw", 2, 1, 1, 5, 7, 0, 0);
        ticks(6);
        expect_all("t2_one", 2, 1, 1, 5, 1, 0, 0);
        pulse(1'b0, 1'b0, 1'b0, 1'b1);
        expect_all("flag2", 4, 1, 0, 5, 0, 0, 1);
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("rearm2", 0, 0, 0, 7, 7, 0, 0);

        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(1);
        expect_all("pre_rst", 2, 1, 1, 7, 6, 0, 0);
        start_button = 1'b1;
        @(posedge clk_four);
        #3;
        reset = 1'b1;
        #1;
        expect_all("async_rst", 0, 0, 0, 7, 7, 0, 0);
        cyc();
        cyc();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) cyc();
        expect_all("held_start", 0, 0, 0, 7, 7, 0, 0);
        start_button = 1'b0;
        cyc();
        pulse(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("repress", 1, 0, 1, 7, 7, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
